icg_gate_ctrl: RTL and testbench

- Enable-side controller for the asynchronous-enable integrated clock gate: decides when a downstream clock domain may be gated and drives the gate's enable.
- Confirms each transition through the gate's synchronised enable feedback (async_en_out looped back).
- Provides idle hysteresis, wake handshake, ack timeout and a test override.
- Runs on the free-running (ungated) clock that feeds the gate.

---
 rtl/icg_gate_ctrl.sv | 151 +++++++++++++++
 tb/tb_icg_gate_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icg_gate_ctrl.sv
// Enable-side controller for an asynchronous-enable integrated clock gate.
// Define ICG_GATE_CTRL_STATS_EN to build the gated-cycle statistics counter.
module icg_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int ACK_TIMEOUT = 8,
    parameter int GCNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              busy,
    input  logic              sleep_allow,
    input  logic              wake_req,
    input  logic              tst_en,
    input  logic              en_ack,
    output logic              icg_en,
    output logic              gated,
    output logic              wake_ack,
    output logic              ack_err,
    output logic [GCNT_W-1:0] gated_cycles
);
    localparam int IDLE_W = $clog2(IDLE_CYCLES) + 1;
    localparam int TMR_W  = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_IDLE,
        S_GATE_WAIT,
        S_GATED,
        S_WAKE_WAIT
    } state_t;

    state_t            state_reg;
    logic [IDLE_W-1:0] idle_cnt_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic              icg_en_reg;
    logic              gated_reg;
    logic              wake_ack_reg;
    logic              ack_err_reg;
    logic              qi;

    assign qi = !busy && sleep_allow && !wake_req && !tst_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_RUN;
            idle_cnt_reg <= '0;
            timer_reg    <= '0;
            icg_en_reg   <= 1'b1;
            gated_reg    <= 1'b0;
            wake_ack_reg <= 1'b0;
            ack_err_reg  <= 1'b0;
        end else begin
            wake_ack_reg <= 1'b0;
            if (tst_en) begin
                // Test override: drop straight back to RUN, silently.
                state_reg    <= S_RUN;
                idle_cnt_reg <= '0;
                timer_reg    <= '0;
                icg_en_reg   <= 1'b1;
                gated_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    S_RUN: begin
                        icg_en_reg <= 1'b1;
                        if (qi) begin
                            state_reg    <= S_IDLE;
                            idle_cnt_reg <= IDLE_LOAD;
                        end
                    end
                    S_IDLE: begin
                        if (!qi) begin
                            state_reg <= S_RUN;
                        end else if (idle_cnt_reg == '0) begin
                            state_reg  <= S_GATE_WAIT;
                            icg_en_reg <= 1'b0;
                            timer_reg  <= '0;
                        end else begin
                            idle_cnt_reg <= idle_cnt_reg - IDLE_W'(1);
                        end
                    end
                    S_GATE_WAIT: begin
                        // An abort outranks a simultaneous acknowledge.
                        if (!qi) begin
                            state_reg  <= S_WAKE_WAIT;
                            icg_en_reg <= 1'b1;
                            timer_reg  <= '0;
                        end else if (!en_ack) begin
                            state_reg <= S_GATED;
                            gated_reg <= 1'b1;
                        end else if (timer_reg == TMR_LAST) begin
                            state_reg   <= S_RUN;
                            icg_en_reg  <= 1'b1;
                            ack_err_reg <= 1'b1;
                        end else begin
                            timer_reg <= timer_reg + TMR_W'(1);
                        end
                    end
                    S_GATED: begin
                        if (!qi) begin
                            state_reg  <= S_WAKE_WAIT;
                            icg_en_reg <= 1'b1;
                            gated_reg  <= 1'b0;
                            timer_reg  <= '0;
                        end
                    end
                    S_WAKE_WAIT: begin
                        if (en_ack) begin
                            state_reg    <= S_RUN;
                            wake_ack_reg <= 1'b1;
                        end else if (timer_reg == TMR_LAST) begin
                            state_reg   <= S_RUN;
                            ack_err_reg <= 1'b1;
                        end else begin
                            timer_reg <= timer_reg + TMR_W'(1);
                        end
                    end
                    default: begin
                        state_reg  <= S_RUN;
                        icg_en_reg <= 1'b1;
                        gated_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // tst_en must turn the clock on without waiting for an edge.
    assign icg_en   = icg_en_reg | tst_en;
    assign gated    = gated_reg;
    assign wake_ack = wake_ack_reg;
    assign ack_err  = ack_err_reg;

`ifdef ICG_GATE_CTRL_STATS_EN
    logic [GCNT_W-1:0] gated_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_cnt_reg <= '0;
        end else if (state_reg == S_GATED && gated_cnt_reg != '1) begin
            gated_cnt_reg <= gated_cnt_reg + GCNT_W'(1);
        end
    end

    assign gated_cycles = gated_cnt_reg;
`else
    assign gated_cycles = '0;
`endif

endmodule

// File: tb/tb_icg_gate_ctrl.sv
// Self-checking bench for icg_gate_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a mode/streak-based reference model.
`timescale 1ns/1ps
module tb_icg_gate_ctrl;
    localparam int IDLE_CYCLES = 16;
    localparam int ACK_TIMEOUT = 8;
    localparam int GCNT_W      = 32;
`ifdef ICG_GATE_CTRL_STATS_EN
    localparam logic [63:0] EXP_GATED_100 = 64'd100;
`else
    localparam logic [63:0] EXP_GATED_100 = 64'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy = 1'b1;
    logic sleep_allow = 1'b0;
    logic wake_req = 1'b0;
    logic tst_en = 1'b0;
    logic en_ack = 1'b1;
    logic icg_en, gated, wake_ack, ack_err;
    logic [GCNT_W-1:0] gated_cycles;

    always #5 clk = ~clk;

    icg_gate_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .GCNT_W     (GCNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .busy        (busy),
        .sleep_allow (sleep_allow),
        .wake_req    (wake_req),
        .tst_en      (tst_en),
        .en_ack      (en_ack),
        .icg_en      (icg_en),
        .gated       (gated),
        .wake_ack    (wake_ack),
        .ack_err     (ack_err),
        .gated_cycles(gated_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: clock ON / off-REQuested / OFF / WAKing, with a
    // streak of consecutive idle cycles and a count of cycles spent waiting.
    typedef enum int {M_ON, M_REQ, M_OFF, M_WAKE} mmode_t;
    mmode_t m_mode   = M_ON;
    int     m_streak = 0;
    int     m_wait   = 0;
    logic   m_err    = 1'b0;
    logic   m_wack   = 1'b0;
    longint m_cnt    = 0;

    // Gate feedback emulation: 0 follow icg_en 2 cycles late, 1 stuck high,
    // 2 stuck low, 3 random.
    int   ack_mode = 0;
    logic pipe0 = 1'b1;
    logic pipe1 = 1'b1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_ON; m_streak = 0; m_wait = 0;
        m_err = 1'b0; m_wack = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic qi;
        qi = !busy && sleep_allow && !wake_req && !tst_en;
        m_wack = 1'b0;
`ifdef ICG_GATE_CTRL_STATS_EN
        if (m_mode == M_OFF && m_cnt < (longint'(1) << GCNT_W) - 1) m_cnt++;
`endif
        if (tst_en) begin
            m_mode = M_ON; m_streak = 0;
        end else begin
            case (m_mode)
                M_ON: begin
                    if (!qi) m_streak = 0;
                    else begin
                        m_streak++;
                        if (m_streak > IDLE_CYCLES) begin m_mode = M_REQ; m_wait = 0; end
                    end
                end
                M_REQ: begin
                    if (!qi) begin m_mode = M_WAKE; m_wait = 0; end
                    else if (!en_ack) m_mode = M_OFF;
                    else begin
                        m_wait++;
                        if (m_wait == ACK_TIMEOUT) begin m_err = 1'b1; m_mode = M_ON; m_streak = 0; end
                    end
                end
                M_OFF: begin
                    if (!qi) begin m_mode = M_WAKE; m_wait = 0; end
                end
                default: begin
                    if (en_ack) begin m_mode = M_ON; m_wack = 1'b1; m_streak = 0; end
                    else begin
                        m_wait++;
                        if (m_wait == ACK_TIMEOUT) begin m_err = 1'b1; m_mode = M_ON; m_streak = 0; end
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        logic exp_on;
        exp_on = (m_mode == M_ON || m_mode == M_WAKE) || tst_en;
        check("icg_en", {63'd0, icg_en}, {63'd0, exp_on});
        check("gated", {63'd0, gated}, {63'd0, m_mode == M_OFF});
        check("wake_ack", {63'd0, wake_ack}, {63'd0, m_wack});
        check("ack_err", {63'd0, ack_err}, {63'd0, m_err});
        check("gated_cycles", 64'(gated_cycles), 64'(m_cnt));
    endtask

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, then refresh the emulated feedback 2 ns later.
    task automatic tick();
        @(negedge clk);
        if (rst_n) compare_all();
        @(posedge clk);
        if (rst_n) model_step();
        #2;
        pipe1 = pipe0;
        pipe0 = icg_en;
        case (ack_mode)
            0:       en_ack = pipe1;
            1:       en_ack = 1'b1;
            2:       en_ack = 1'b0;
            default: en_ack = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_icg_en", {63'd0, icg_en}, 64'd1);
        check("rst_gated", {63'd0, gated}, 64'd0);
        check("rst_wake_ack", {63'd0, wake_ack}, 64'd0);
        check("rst_ack_err", {63'd0, ack_err}, 64'd0);
        check("rst_gated_cycles", 64'(gated_cycles), 64'd0);
        model_reset();
        pipe0 = 1'b1; pipe1 = 1'b1; en_ack = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return icg_en;
            1:       return gated;
            2:       return wake_ack;
            default: return ack_err;
        endcase
    endfunction

    // Ticks until the selected output equals val; -1 if max ticks expire.
    task automatic run_until(input int sel, input logic val, input int max, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < max) begin
            tick();
            n++;
            hit = (pick(sel) === val);
        end
        if (!hit) n = -1;
    endtask

    initial begin
        int n;
        int busy_pct;
        apply_reset();

        // Idle hysteresis, gate confirmation, dwell, then wake handshake.
        busy = 1'b0; sleep_allow = 1'b1; ack_mode = 0;
        run_until(0, 1'b0, 40, n);
        check("gate_latency", 64'(n), 64'd17);
        run_until(1, 1'b1, 20, n);
        check("gated_latency", 64'(n), 64'd2);
        repeat (100) tick();
        check("gated_cycles_100", 64'(gated_cycles), EXP_GATED_100);
        wake_req = 1'b1;
        tick();
        check("wake_icg_en", {63'd0, icg_en}, 64'd1);
        check("wake_gated", {63'd0, gated}, 64'd0);
        run_until(2, 1'b1, 20, n);
        check("wake_ack_latency", 64'(n), 64'd2);
        tick();
        check("wake_ack_width", {63'd0, wake_ack}, 64'd0);

        // One-cycle busy pulse mid-idle: no gating, then a full reload.
        wake_req = 1'b0;
        repeat (7) tick();
        check("idle_icg_en", {63'd0, icg_en}, 64'd1);
        busy = 1'b1;
        tick();
        busy = 1'b0;
        check("abort_icg_en", {63'd0, icg_en}, 64'd1);
        run_until(0, 1'b0, 40, n);
        check("reload_latency", 64'(n), 64'd17);

        // Feedback stuck high: timeout, error sticks until reset.
        apply_reset();
        ack_mode = 1;
        run_until(0, 1'b0, 40, n);
        check("stuck_gate_latency", 64'(n), 64'd17);
        run_until(3, 1'b1, 20, n);
        check("ack_timeout_latency", 64'(n), 64'd8);
        check("timeout_icg_en", {63'd0, icg_en}, 64'd1);
        repeat (30) tick();
        check("ack_err_sticky", {63'd0, ack_err}, 64'd1);

        // Test override while gated.
        apply_reset();
        ack_mode = 0;
        run_until(0, 1'b0, 40, n);
        run_until(1, 1'b1, 20, n);
        check("pre_tst_gated", {63'd0, gated}, 64'd1);
        tst_en = 1'b1;
        #1;
        check("tst_icg_comb", {63'd0, icg_en}, 64'd1);
        tick();
        check("tst_gated", {63'd0, gated}, 64'd0);
        check("tst_wake_ack", {63'd0, wake_ack}, 64'd0);
        check("tst_ack_err", {63'd0, ack_err}, 64'd0);
        tst_en = 1'b0;
        run_until(0, 1'b0, 40, n);
        check("tst_regate_latency", 64'(n), 64'd17);

        // Randomized traffic against the model.
        apply_reset();
        for (int seg = 0; seg < 60; seg++) begin
            n = int'($urandom_range(0, 9));
            ack_mode = (n < 6) ? 0 : (n < 7) ? 1 : (n < 8) ? 2 : 3;
            busy_pct = ($urandom_range(0, 1) == 0) ? 2 : 30;
            for (int c = 0; c < 64; c++) begin
                busy        = ($urandom_range(0, 99) < busy_pct);
                sleep_allow = ($urandom_range(0, 99) < 95);
                wake_req    = ($urandom_range(0, 99) < 1);
                tst_en      = ($urandom_range(0, 199) < 1);
                tick();
            end
        end
        tst_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
